// File: rtl/status_ctrl_pkg.sv
// Shared types and constants for the status sticky controller.
// Holds the read-sequencing state encoding and the snapshot reset value.
package status_ctrl_pkg;

   localparam int unsigned STATUS_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SNAP  = 2'd1,
      HOLD  = 2'd2,
      CLEAR = 2'd3
   } state_t;

   localparam logic [STATUS_W-1:0] RD_DATA_RST = '0;

endpackage

// File: rtl/status_sticky_ctrl_capture.sv
// Per-bit event detection for the status nets (module status_event_capture).
// STATUS_CTRL_EDGE_EN selects rising-edge events; otherwise events are the raw level.
module status_event_capture #(
   parameter int unsigned NUM_INPUTS = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NUM_INPUTS-1:0] status_in,
   output logic [NUM_INPUTS-1:0] ev
);

`ifdef STATUS_CTRL_EDGE_EN
   logic [NUM_INPUTS-1:0] hist;

   always_ff @(posedge clock) begin
      if (reset) hist <= '0;
      else       hist <= status_in;
   end

   assign ev = status_in & ~hist;
`else
   // Level build keeps no history; clock and reset are intentionally unused.
   logic unused_clk_rst;
   assign unused_clk_rst = clock ^ reset;
   assign ev = status_in;
`endif

endmodule

// File: rtl/status_sticky_ctrl.sv
// Status capture and firmware read handshake: sticky/transparent bits, snapshot, clear-after-read, irq.
// Optional build macro: STATUS_CTRL_EDGE_EN (sticky bits set on rising edges instead of levels).
module status_sticky_ctrl
   import status_ctrl_pkg::*;
#(
   parameter int unsigned          NUM_INPUTS  = 8,
   parameter logic [STATUS_W-1:0]  STICKY_MASK = 8'h00
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NUM_INPUTS-1:0] status_in,
   input  logic [STATUS_W-1:0]   int_mask,
   input  logic                  rd_req,
   output logic                  rd_ack,
   output logic [STATUS_W-1:0]   rd_data,
   output logic                  irq
);

   localparam logic [STATUS_W-1:0] LIVE_MASK = STATUS_W'((16'h1 << NUM_INPUTS) - 16'h1);
   localparam logic [STATUS_W-1:0] SMASK     = STICKY_MASK & LIVE_MASK;

   state_t                state;
   logic [STATUS_W-1:0]   sticky_q;
   logic [STATUS_W-1:0]   sticky_next;
   logic [STATUS_W-1:0]   snap_val;
   logic [STATUS_W-1:0]   ev_w;
   logic [STATUS_W-1:0]   stat_w;
   logic [NUM_INPUTS-1:0] ev;

   status_event_capture #(
      .NUM_INPUTS (NUM_INPUTS)
   ) u_capture (
      .clock     (clock),
      .reset     (reset),
      .status_in (status_in),
      .ev        (ev)
   );

   always_comb begin
      ev_w   = '0;
      stat_w = '0;
      ev_w[NUM_INPUTS-1:0]   = ev;
      stat_w[NUM_INPUTS-1:0] = status_in;
   end

   // A new event in the clear cycle is OR-ed in after the clear, so it survives.
   always_comb begin
      if (state == CLEAR) sticky_next = (sticky_q & ~(rd_data & SMASK)) | (ev_w & SMASK);
      else                sticky_next = (sticky_q | ev_w) & SMASK;
      snap_val = ((sticky_q | ev_w) & SMASK) | (stat_w & ~SMASK);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         sticky_q <= '0;
         rd_data  <= RD_DATA_RST;
         rd_ack   <= 1'b0;
         irq      <= 1'b0;
      end else begin
         sticky_q <= sticky_next;
         irq      <= |(sticky_q & int_mask & SMASK);
         case (state)
            IDLE: begin
               if (rd_req) state <= SNAP;
            end
            SNAP: begin
               if (rd_req) begin
                  rd_data <= snap_val;
                  rd_ack  <= 1'b1;
                  state   <= HOLD;
               end else begin
                  state   <= IDLE;
               end
            end
            HOLD: begin
               if (!rd_req) begin
                  rd_ack <= 1'b0;
                  state  <= CLEAR;
               end
            end
            CLEAR: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_status_sticky_ctrl.sv
// Self-checking bench for status_sticky_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the read handshake.
module tb_status_sticky_ctrl;

   localparam int unsigned NI = 8;
   localparam logic [7:0]  SM = 8'h8F;
`ifdef STATUS_CTRL_EDGE_EN
   localparam bit EDGE_BUILD = 1'b1;
`else
   localparam bit EDGE_BUILD = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset;
   logic [NI-1:0] status_in;
   logic [7:0]    int_mask;
   logic          rd_req;
   logic          rd_ack;
   logic [7:0]    rd_data;
   logic          irq;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   status_sticky_ctrl #(
      .NUM_INPUTS  (NI),
      .STICKY_MASK (SM)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .status_in (status_in),
      .int_mask  (int_mask),
      .rd_req    (rd_req),
      .rd_ack    (rd_ack),
      .rd_data   (rd_data),
      .irq       (irq)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pending events, last snapshot, and where the read handshake stands.
   logic [7:0] m_pend, m_prev, m_rd, m_ev;
   bit         m_ack, m_irq, m_snap_due, m_clr_due, m_irq_n;

   always @(posedge clock) begin
      if (reset) begin
         m_pend = '0; m_prev = '0; m_rd = '0;
         m_ack = 0; m_irq = 0; m_snap_due = 0; m_clr_due = 0;
      end else begin
         m_ev    = (EDGE_BUILD ? (status_in & ~m_prev) : status_in) & SM;
         m_irq_n = |(m_pend & int_mask & SM);
         if (m_clr_due) begin
            m_pend    = (m_pend & ~(m_rd & SM)) | m_ev;
            m_clr_due = 0;
         end else begin
            if (m_ack) begin
               if (!rd_req) begin m_ack = 0; m_clr_due = 1; end
            end else if (m_snap_due) begin
               m_snap_due = 0;
               if (rd_req) begin
                  m_rd  = ((m_pend | m_ev) & SM) | (status_in & ~SM);
                  m_ack = 1;
               end
            end else if (rd_req) begin
               m_snap_due = 1;
            end
            m_pend = m_pend | m_ev;
         end
         m_prev = status_in;
         m_irq  = m_irq_n;
      end
   end

   always @(negedge clock) begin
      if (cmp_en) begin
         check("model_rd_ack",  {7'b0, rd_ack}, {7'b0, m_ack});
         check("model_rd_data", rd_data, m_rd);
         check("model_irq",     {7'b0, irq}, {7'b0, m_irq});
      end
   end

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   // Full read: request, bounded wait for ack, drop request, let the clear cycle pass.
   task automatic do_read(output logic [7:0] data);
      int lat = 0;
      rd_req = 1'b1;
      while (lat < 8) begin
         tick();
         lat++;
         if (rd_ack) break;
      end
      check("read_latency", 8'(lat), 8'd2);
      data   = rd_data;
      rd_req = 1'b0;
      tick();
      check("ack_drop", {7'b0, rd_ack}, 8'd0);
      tick();
   endtask

   logic [7:0] d;

   initial begin
      reset = 1'b1; status_in = '0; int_mask = '0; rd_req = 1'b0;
      tick();
      cmp_en = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      check("rst_ack",  {7'b0, rd_ack}, 8'd0);
      check("rst_data", rd_data, 8'h00);
      check("rst_irq",  {7'b0, irq}, 8'd0);

      // sticky pulse on bit 3 -> irq two edges later, read, clear
      int_mask = 8'h08; status_in = 8'h08;
      tick();
      status_in = 8'h00;
      check("irq_lag1", {7'b0, irq}, 8'd0);
      tick();
      check("irq_lag2", {7'b0, irq}, 8'd1);
      do_read(d);
      check("read_bit3", d, 8'h08);
      check("irq_at_clear", {7'b0, irq}, 8'd1);
      tick();
      check("irq_after_clear", {7'b0, irq}, 8'd0);

      // transparent bits frozen during HOLD
      status_in = 8'h50; rd_req = 1'b1;
      tick(); tick();
      check("transp_ack",  {7'b0, rd_ack}, 8'd1);
      check("transp_data", rd_data, 8'h50);
      status_in = 8'h70;
      tick();
      check("transp_hold", rd_data, 8'h50);
      rd_req = 1'b0;
      tick(); tick();
      status_in = 8'h00;
      tick();

      // events during HOLD and on the clear cycle survive
      status_in = 8'h01; tick(); status_in = 8'h00;
      rd_req = 1'b1; tick(); tick();
      check("hold_ev_first", rd_data, 8'h01);
      status_in = 8'h02; tick(); status_in = 8'h00; tick();
      rd_req = 1'b0; tick();
      status_in = 8'h02; tick(); status_in = 8'h00;
      do_read(d);
      check("hold_ev_second", d, 8'h02);

      // aborted request leaves pending bits intact
      status_in = 8'h01; tick(); status_in = 8'h00;
      rd_req = 1'b1; tick();
      rd_req = 1'b0; tick();
      check("abort_ack1", {7'b0, rd_ack}, 8'd0);
      tick();
      check("abort_ack2", {7'b0, rd_ack}, 8'd0);
      do_read(d);
      check("abort_read", d, 8'h01);

      // reset while holding a snapshot
      int_mask = 8'h81; status_in = 8'h81; tick(); status_in = 8'h00;
      rd_req = 1'b1; tick(); tick();
      check("rsthold_ack",  {7'b0, rd_ack}, 8'd1);
      check("rsthold_data", rd_data, 8'h81);
      tick();
      check("rsthold_irq", {7'b0, irq}, 8'd1);
      reset = 1'b1; rd_req = 1'b0; tick();
      check("rsthold_ack0", {7'b0, rd_ack}, 8'd0);
      check("rsthold_irq0", {7'b0, irq}, 8'd0);
      reset = 1'b0; tick();
      do_read(d);
      check("rsthold_read", d, 8'h00);

      // level held high across reads
      status_in = 8'h04;
      do_read(d);
      check("held_first", d, 8'h04);
      do_read(d);
      check("held_second", d, EDGE_BUILD ? 8'h00 : 8'h04);
      status_in = 8'h00;
      tick();

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         status_in = 8'($urandom) & 8'($urandom) & 8'($urandom);
         if ($urandom_range(0, 15) == 0) int_mask = 8'($urandom);
         if ($urandom_range(0, 3) == 0)  rd_req = ~rd_req;
         reset = ($urandom_range(0, 249) == 0);
         tick();
      end
      reset = 1'b0; rd_req = 1'b0;
      tick(); tick();
      cmp_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/status_sticky_ctrl.md
# status_sticky_ctrl

Sequencing controller in front of the 8-bit status register path. It captures up to eight status nets into per-bit sticky or transparent holding bits and presents a coherent snapshot to the firmware-facing read port through a request/acknowledge handshake. After the read completes it clears only the reported sticky bits, and it raises a masked interrupt while any enabled sticky bit is pending.

## Interface
- NUM_INPUTS, 8, number of live status bits (1..8); bits at and above NUM_INPUTS read 0.
- STICKY_MASK, 8'h00, per-bit mode: 1 = sticky (set by event, cleared after read), 0 = transparent (sampled level).
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- status_in  input  NUM_INPUTS  raw status nets, synchronous to clock.
- int_mask  input  8  interrupt enable per bit; only sticky bits contribute.
- rd_req  input  1  read request from the bus-side agent; level, held until rd_ack.
- rd_ack  output  1  snapshot valid and stable on rd_data.
- rd_data  output  8  snapshot of status bits.
- irq  output  1  registered OR of (sticky_q & int_mask & STICKY_MASK).

## Operation
- Event capture: each cycle, sticky_q[i] <= sticky_q[i] | ev[i] for sticky bits. Without the macro, ev = status_in; with it, ev is the rising edge of status_in. Transparent bits keep no state.
- FSM states: IDLE, SNAP, HOLD, CLEAR.
- IDLE: rd_req=1 -> SNAP.
- SNAP: if rd_req=1, load rd_data. Sticky bits load sticky_q | ev; transparent bits load status_in. Then set rd_ack=1 and go to HOLD. If rd_req=0, abort to IDLE: no snapshot, no clear, rd_ack stays 0.
- HOLD: rd_data and rd_ack are frozen. rd_req=0 -> CLEAR with rd_ack=0.
- CLEAR: one cycle. sticky_q <= (sticky_q & ~(rd_data & STICKY_MASK)) | ev, so a new event on the same cycle wins over the clear. Then go to IDLE.
- Events arriving in SNAP, HOLD or CLEAR are never lost; they remain pending for the next read.
- rd_data holds its last value outside HOLD. Only values seen while rd_ack=1 are valid.
- irq is recomputed every cycle from sticky_q. It drops the cycle after the CLEAR edge if no enabled bits remain.

## Timing
- Reset values: state=IDLE, sticky_q=0, edge history=0, rd_data=0, rd_ack=0, irq=0.
- Reset asserted in any state returns to IDLE on the next edge; an in-flight read is dropped and rd_ack falls.
- rd_req sampled high at edge k -> SNAP; at edge k+1, rd_ack=1 and rd_data valid. Latency is 2 cycles.
- rd_req sampled low in HOLD at edge m -> rd_ack=0 after edge m; clear applied at edge m+1. Earliest next SNAP entry is edge m+2.
- Minimum read cycle is 4 clocks. Back-to-back requests are legal.
- irq lags a setting event by 2 edges: one edge into sticky_q, one edge into irq.

## Configuration
- STATUS_CTRL_EDGE_EN defined: sticky bits set only on a 0->1 transition of status_in, using one history register per bit that resets to 0. A level held high sets a bit once.
- STATUS_CTRL_EDGE_EN undefined: sticky bits are level-set, and a level held high re-sets the bit immediately after CLEAR. No history flops are built.
- Transparent bits behave identically in both builds.

## Structure
- Package status_ctrl_pkg holds:
  - the state enum (IDLE, SNAP, HOLD, CLEAR);
  - STATUS_W = 8;
  - the reset constant for rd_data.
- One sub-module: status_event_capture. It is per-bit-vector event detection (edge or level under the macro) and returns ev[NUM_INPUTS-1:0]. The FSM, sticky bits, snapshot and irq live in the top.

## Test plan
- Reset then idle: rd_ack=0, rd_data=0, irq=0. Pulse status_in[3] for 1 cycle with STICKY_MASK=8'h08 and int_mask=8'h08 -> irq=1 two edges later. A read returns rd_data=8'h08; after CLEAR, irq=0.
- Transparent bit: STICKY_MASK=8'h00, status_in=8'h5A held -> rd_ack 2 cycles after rd_req with rd_data=8'h5A. Change status_in to 8'hFF during HOLD -> rd_data stays 8'h5A.
- Event during HOLD: sticky bit 0 reported. Pulse status_in[1] (sticky) in HOLD, then again exactly on the CLEAR cycle -> bit 0 cleared, bit 1 remains set, next read returns 8'h02.
- Abort: rd_req high 1 cycle, dropped in SNAP -> rd_ack never asserts and sticky_q is unchanged.
- Reset mid-HOLD: rd_ack=1 with sticky 8'h81 pending, assert reset -> next edge rd_ack=0, irq=0, and a subsequent read returns 8'h00.
- Edge build, STATUS_CTRL_EDGE_EN defined: hold status_in[2]=1 across a full read -> the second read returns 8'h00. In the level build, the second read returns 8'h04.
